// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu,
// 32 iteration steps per operation, one-cycle div_ok pulse with the result.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [66:0] es_to_div_bus,
  output logic [32:0] div_to_es_bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic div_en, m_in, u_in;
  logic [31:0] src1, src2;
  logic use_mod, sa, sb, dz;
  logic [31:0] rem, quo, d, q, r;
  logic [4:0] cnt;
  logic [63:0] sh;
  logic [32:0] t;
  logic start, step, sa_in, sb_in;
  assign {div_en, m_in, u_in, src1, src2} = es_to_div_bus;
  assign sa_in = !u_in & src1[31];
  assign sb_in = !u_in & src2[31];
  assign start = state == IDLE && div_en && !flush;
  assign step  = state == CALC && div_en && !flush;
  assign sh = {rem, quo} << 1;
  assign t = {1'b0, sh[63:32]} - {1'b0, d};
  always_comb begin
    next = flush ? IDLE
         : state == IDLE ? (div_en ? (src2 == 32'd0 ? DONE : CALC) : IDLE)
         : state == CALC ? (!div_en ? IDLE : cnt == 5'd31 ? DONE : CALC)
         : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      use_mod <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dz      <= 1'b0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      d       <= 32'd0;
      cnt     <= 5'd0;
    end else begin
      state <= next;
      if (next == IDLE) dz <= 1'b0;
      if (start) begin
        use_mod <= m_in;
        sa      <= sa_in;
        sb      <= sb_in;
        rem     <= 32'd0;
        quo     <= sa_in ? -src1 : src1;
        d       <= sb_in ? -src2 : src2;
        cnt     <= 5'd0;
        dz      <= src2 == 32'd0;
      end else if (step) begin
        rem <= t[32] ? sh[63:32] : t[31:0];
        quo <= {sh[31:1], ~t[32]};
        cnt <= cnt + 5'd1;
      end
    end
  end
  // on divide-by-zero quo still holds |src1|, so re-applying sa recovers raw src1
  assign q = dz ? 32'hFFFF_FFFF : ((sa ^ sb) ? -quo : quo);
  assign r = dz ? (sa ? -quo : quo) : (sa ? -rem : rem);
  assign div_to_es_bus = {use_mod ? r : q, state == DONE};
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed tests for div_iter with hand-computed results and latencies.
module tb_div_iter;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic div_en = 1'b0, use_mod = 1'b0, is_uns = 1'b0;
  logic [31:0] s1 = 32'd0, s2 = 32'd0;
  logic [66:0] bus;
  logic [32:0] out;
  int checks = 0, errors = 0;
  assign bus = {div_en, use_mod, is_uns, s1, s2};
  always #5 clk = ~clk;
  div_iter dut (.clk(clk), .reset(reset), .flush(flush), .es_to_div_bus(bus), .div_to_es_bus(out));

  task automatic run_op(input logic m, input logic u, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp, input string name);
    int n;
    bit got;
    @(negedge clk);
    use_mod = m; is_uns = u; s1 = a; s2 = b; div_en = 1'b1;
    n = 0; got = 0;
    while (n < 100 && !got) begin
      @(posedge clk); #1; n++; got = out[0];
    end
    div_en = 1'b0;
    checks++;
    if (!got || n !== exp_lat) begin
      errors++; $display("FAIL %s latency got %0d cycles expected %0d", name, n, exp_lat);
    end
    checks++;
    if (out[32:1] !== exp) begin
      errors++; $display("FAIL %s result got %h expected %h", name, out[32:1], exp);
    end
    @(posedge clk); #1;
    checks++;
    if (out[0] !== 1'b0) begin
      errors++; $display("FAIL %s div_ok width got %b expected 0", name, out[0]);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (out !== 33'd0) begin errors++; $display("FAIL reset_out got %h expected 0", out); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out !== 33'd0) begin errors++; $display("FAIL idle_out got %h expected 0", out); end
  endtask

  task automatic test_unsigned;
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 33, 32'd14, "udiv_100_7");
    run_op(1'b1, 1'b1, 32'd100, 32'd7, 33, 32'd2, "umod_100_7");
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, "udiv_max_1");
    run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, "umod_max_1");
  endtask

  task automatic test_signed;
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "sdiv_m7_2");
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "smod_m7_2");
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd3, "sdiv_m7_m2");
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF, "smod_m7_m2");
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, "sdiv_ovf");
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, "smod_ovf");
  endtask

  task automatic test_div_zero;
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, "sdiv_zero");
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, "smod_zero");
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, "smod_zero_neg");
  endtask

  task automatic watch_no_ok(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out[0]) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL %s div_ok got 1 expected 0", name); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    use_mod = 1'b0; is_uns = 1'b1; s1 = 32'd100; s2 = 32'd7; div_en = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); flush = 1'b1; div_en = 1'b0;
    @(negedge clk); flush = 1'b0;
    watch_no_ok("flush_abort");
    run_op(1'b0, 1'b1, 32'd50, 32'd5, 33, 32'd10, "after_flush");
  endtask

  task automatic test_flush_start;
    @(negedge clk);
    use_mod = 1'b0; is_uns = 1'b1; s1 = 32'd9; s2 = 32'd0; div_en = 1'b1; flush = 1'b1;
    @(negedge clk); div_en = 1'b0; flush = 1'b0;
    watch_no_ok("flush_priority");
  endtask

  task automatic test_drop_en;
    @(negedge clk);
    use_mod = 1'b0; is_uns = 1'b1; s1 = 32'd100; s2 = 32'd7; div_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); div_en = 1'b0;
    watch_no_ok("drop_en");
    run_op(1'b0, 1'b1, 32'd81, 32'd9, 33, 32'd9, "after_drop");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    use_mod = 1'b0; is_uns = 1'b1; s1 = 32'd100; s2 = 32'd7; div_en = 1'b1;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== 33'd0) begin errors++; $display("FAIL async_reset got %h expected 0", out); end
    @(negedge clk); reset = 1'b0; div_en = 1'b0;
    run_op(1'b1, 1'b1, 32'd100, 32'd7, 33, 32'd2, "after_reset");
  endtask

  task automatic test_back_to_back;
    int n;
    bit got;
    @(negedge clk);
    use_mod = 1'b0; is_uns = 1'b1; s1 = 32'd81; s2 = 32'd9; div_en = 1'b1;
    n = 0; got = 0;
    while (n < 100 && !got) begin @(posedge clk); #1; n++; got = out[0]; end
    checks++;
    if (!got || out[32:1] !== 32'd9) begin
      errors++; $display("FAIL b2b_first got ok=%b res=%0d expected ok=1 res=9", got, out[32:1]);
    end
    s2 = 32'd10;
    n = 0; got = 0;
    while (n < 100 && !got) begin @(posedge clk); #1; n++; got = out[0]; end
    div_en = 1'b0;
    checks++;
    if (!got || n !== 34) begin errors++; $display("FAIL b2b_gap got %0d cycles expected 34", n); end
    checks++;
    if (out[32:1] !== 32'd8) begin errors++; $display("FAIL b2b_second got %0d expected 8", out[32:1]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_flush;
    test_flush_start;
    test_drop_en;
    test_async_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
